wm_appliance_model: RTL

- Synthesizable model of the washing machine hardware that sits on the other side of the controller's actuator/sensor interface.
- Consumes the controller commands (motor_on, water_pump_on, door_locked).
- Produces the sensor inputs the controller expects (lid_closed, water_full, load_balanced, load_detected).
- Used for closed-loop FPGA/board bring-up and system simulation of the controller.

---
 rtl/wm_appliance_model.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wm_appliance_model.sv
// Washing-machine plant model: turns controller actuator commands into sensor readings.
// Outputs are registered; level/speed move once per TICK_DIV clocks, water_full/load_balanced lag by one clock.
`timescale 1ns/1ps
module wm_appliance_model #(
  parameter int TICK_DIV    = 4,
  parameter int LVL_W       = 8,
  parameter int LOW_LVL     = 40,
  parameter int MED_LVL     = 80,
  parameter int HIGH_LVL    = 120,
  parameter int FILL_RATE   = 2,
  parameter int DRAIN_RATE  = 3,
  parameter int SPIN_MAX    = 15,
  parameter int IMBAL_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor_on,
  input  logic             water_pump_on,
  input  logic             drain_on,
  input  logic             door_locked,
  input  logic [1:0]       water_level_select,
  input  logic             lid_open_req,
  input  logic             lid_close_req,
  input  logic             load_present,
  input  logic             imbalance_inject,
  output logic             lid_closed,
  output logic             water_full,
  output logic             load_balanced,
  output logic             load_detected,
  output logic [LVL_W-1:0] water_level,
  output logic [3:0]       drum_speed,
  output logic             lid_fault,
  output logic             overflow
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IMB_W = $clog2(IMBAL_LIMIT + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = '1;

  typedef enum logic [1:0] {LID_OPEN, LID_CLOSED, LID_LOCKED} lid_state_t;

  lid_state_t       lid_q, lid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [3:0]       speed_q, speed_d;
  logic [IMB_W-1:0] imb_q, imb_d;
  logic             full_q, full_d;
  logic             bal_q, bal_d;
  logic             det_q, det_d;
  logic             fault_q, fault_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic [LVL_W:0]   fill_sum;
  logic [LVL_W-1:0] thr;

  always_comb begin
    tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    fill_sum = {1'b0, level_q} + (LVL_W + 1)'(FILL_RATE);
    level_d  = level_q;
    ovf_d    = ovf_q;
    speed_d  = speed_q;
    if (tick) begin
      if (water_pump_on && !drain_on) begin
        level_d = fill_sum[LVL_W] ? LVL_MAX : fill_sum[LVL_W-1:0];
        if (level_q == LVL_MAX) ovf_d = 1'b1;
      end else if (!water_pump_on && drain_on) begin
        level_d = (level_q < LVL_W'(DRAIN_RATE)) ? '0 : level_q - LVL_W'(DRAIN_RATE);
      end
      if (motor_on) speed_d = (speed_q >= 4'(SPIN_MAX)) ? 4'(SPIN_MAX) : speed_q + 4'd1;
      else          speed_d = (speed_q == 4'd0) ? 4'd0 : speed_q - 4'd1;
    end

    case (water_level_select)
      2'b00:   thr = LVL_W'(LOW_LVL);
      2'b01:   thr = LVL_W'(MED_LVL);
      default: thr = LVL_W'(HIGH_LVL);
    endcase
    full_d = (level_q >= thr);

    // Increment needs speed >= SPIN_MAX/2, so it can never collide with the stop clear.
    imb_d = imb_q;
    if (imbalance_inject && speed_q >= 4'(SPIN_MAX / 2) && imb_q < IMB_W'(IMBAL_LIMIT))
      imb_d = imb_q + IMB_W'(1);
    if (speed_d == 4'd0) imb_d = '0;
    bal_d = (imb_q < IMB_W'(IMBAL_LIMIT));
  end

  always_comb begin
    lid_d   = lid_q;
    fault_d = 1'b0;
    case (lid_q)
      LID_OPEN:   if (lid_close_req && !lid_open_req) lid_d = LID_CLOSED;
      LID_CLOSED: begin
        if (door_locked)                        lid_d = LID_LOCKED;
        else if (lid_open_req && !lid_close_req) lid_d = LID_OPEN;
      end
      LID_LOCKED: begin
        fault_d = lid_open_req;
        if (!door_locked) lid_d = LID_CLOSED;
      end
      default:    lid_d = LID_CLOSED;
    endcase
    det_d = load_present && (lid_d != LID_OPEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lid_q   <= LID_CLOSED;
      cnt_q   <= '0;
      level_q <= '0;
      speed_q <= '0;
      imb_q   <= '0;
      full_q  <= 1'b0;
      bal_q   <= 1'b1;
      det_q   <= 1'b0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      lid_q   <= lid_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      speed_q <= speed_d;
      imb_q   <= imb_d;
      full_q  <= full_d;
      bal_q   <= bal_d;
      det_q   <= det_d;
      fault_q <= fault_d;
      ovf_q   <= ovf_d;
    end
  end

  assign lid_closed    = (lid_q != LID_OPEN);
  assign water_full    = full_q;
  assign load_balanced = bal_q;
  assign load_detected = det_q;
  assign water_level   = level_q;
  assign drum_speed    = speed_q;
  assign lid_fault     = fault_q;
  assign overflow      = ovf_q;

endmodule
